// File: rtl/tri_bus_pkg.sv
// tri_bus_pkg: shared state encoding and width helper for the tri-state bus arbiter.
package tri_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tri_bus_arbiter_pick.sv
// rr_priority_pick: round-robin winner search; rotates req so last+1 sits at bit 0,
// takes the lowest set bit, then maps the position back to a requester index.
module rr_priority_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          hit,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             sh;
    int             pos;

    always_comb begin
        dbl = {req, req};
        sh  = int'(last) + 1;
        rot = dbl[sh +: N];
        hit = |rot;
        pos = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) pos = i;
        end
        idx = IW'((pos + sh) % N);
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter: round-robin owner selection for a shared bufif1 bus, with registered
// one-hot enables, all-off turnaround cycles between tenures and an optional tenure cap.
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int N        = 3,
    parameter int HOLD_MAX = 15,
    parameter int TURN_CYC = 1,
    localparam int OW      = clog2(N)
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  en,
    output logic [OW-1:0] owner,
    output logic          busy,
    output logic          preempt
);

    localparam int            CW     = clog2(HOLD_MAX + 1) > 0 ? clog2(HOLD_MAX + 1) : 1;
    localparam logic [CW-1:0] HOLD_L = CW'(HOLD_MAX);
    localparam logic [1:0]    TURN_L = 2'(TURN_CYC);

    state_e        state_q, state_d;
    logic [N-1:0]  en_q, en_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    turn_q, turn_d;
    logic          busy_q, busy_d;
    logic          preempt_q, preempt_d;
    logic          hit;
    logic [OW-1:0] pick;
    logic          keep;

    rr_priority_pick #(.N(N), .IW(OW)) u_pick (
        .req  (req),
        .last (last_q),
        .hit  (hit),
        .idx  (pick)
    );

    // A set req of the owner with no cap reached keeps the tenure; anything else (incl. X) ends it.
    assign keep = req[owner_q] && (HOLD_MAX == 0 || cnt_q < HOLD_L);

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        turn_d    = turn_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE, TURN: begin
                if (state_q == TURN && turn_q < TURN_L) begin
                    turn_d = turn_q + 2'd1;
                end else if (hit) begin
                    state_d = OWN;
                    en_d    = N'(1) << pick;
                    owner_d = pick;
                    last_d  = pick;
                    cnt_d   = CW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (keep) begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
                end else begin
                    state_d   = TURN;
                    en_d      = '0;
                    turn_d    = 2'd1;
                    preempt_d = req[owner_q] === 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = '0;
            end
        endcase
        busy_d = |en_d;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            en_q      <= '0;
            owner_q   <= '0;
            last_q    <= OW'(N - 1);
            cnt_q     <= '0;
            turn_q    <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            turn_q    <= turn_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign en      = en_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

    en_onehot_a: assert property (@(posedge clk) disable iff (!clrn) $onehot0(en_q) && !$isunknown(en_q));

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb_tri_bus_arbiter: directed checks of grant order, tenure cap, release, async reset
// and turnaround gaps on two configurations of the arbiter.
module tb_tri_bus_arbiter;

    logic       clk;
    logic       clrn;
    logic [2:0] req, req6;
    logic [2:0] en, en6;
    logic [1:0] owner, owner6;
    logic       busy, busy6, preempt, preempt6;
    int         vec;
    int         miss;

    tri_bus_arbiter #(.N(3), .HOLD_MAX(4), .TURN_CYC(1)) u_dut (
        .clk(clk), .clrn(clrn), .req(req), .en(en), .owner(owner), .busy(busy), .preempt(preempt)
    );

    tri_bus_arbiter #(.N(3), .HOLD_MAX(0), .TURN_CYC(2)) u_dut6 (
        .clk(clk), .clrn(clrn), .req(req6), .en(en6), .owner(owner6), .busy(busy6), .preempt(preempt6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle invariants: one-hot enables, busy mirrors en, and the turnaround gap.
    logic [2:0] prev, prev6;
    int         zeros, zeros6;
    bit         had, had6;

    always @(negedge clk) begin
        if (!clrn) begin
            prev = '0; prev6 = '0; zeros = 0; zeros6 = 0; had = 0; had6 = 0;
        end else begin
            chk("onehot", 32'($onehot0(en)), 1);
            chk("onehot6", 32'($onehot0(en6)), 1);
            chk("busy_mon", busy, |en);
            chk("busy6_mon", busy6, |en6);
            if (en != 0) begin
                if (prev != 0) chk("no_switch", en, prev);
                else if (had) chk("gap", 32'(zeros >= 1), 1);
                had = 1; zeros = 0;
            end else zeros++;
            if (en6 != 0) begin
                if (prev6 != 0) chk("no_switch6", en6, prev6);
                else if (had6) chk("gap6", 32'(zeros6 >= 2), 1);
                had6 = 1; zeros6 = 0;
            end else zeros6++;
            prev = en; prev6 = en6;
        end
    end

    logic [2:0] t2 [15] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b010, 3'b010,
                           3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001};
    logic [2:0] t4 [10] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                           3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
    logic [2:0] e;

    initial begin
        vec = 0; miss = 0;
        clrn = 1'b1; req = 3'b111; req6 = 3'b000;
        #1 clrn = 1'b0;
        #1;
        chk("t1_en", en, 0);
        chk("t1_busy", busy, 0);
        chk("t1_owner", owner, 0);
        chk("t1_pre", preempt, 0);
        step();
        chk("t1_en_held", en, 0);
        #1 clrn = 1'b1;
        step();
        chk("t1_grant", en, 3'b001);
        chk("t1_owner0", owner, 0);
        chk("t1_busy1", busy, 1);

        for (int i = 0; i < 15; i++) begin
            step();
            e = t2[i];
            chk("t2_en", en, e);
            chk("t2_pre", preempt, e == 0);
            if (e != 0) chk("t2_owner", owner, e[2] ? 2 : e[1] ? 1 : 0);
        end

        req = 3'b000;
        step(); chk("t3_drop_en", en, 0); chk("t3_drop_pre", preempt, 0);
        step(); chk("t3_idle_en", en, 0);
        req = 3'b010;
        step(); chk("t3_en_a", en, 3'b010); chk("t3_owner", owner, 1);
        step(); chk("t3_en_b", en, 3'b010);
        req = 3'b000;
        step(); chk("t3_rel_en", en, 0); chk("t3_rel_pre", preempt, 0);
        step(); chk("t3_idle", en, 0); chk("t3_idle_busy", busy, 0); chk("t3_idle_pre", preempt, 0);

        req = 3'b001;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_en", en, t4[i]);
            chk("t4_pre", preempt, t4[i] == 0);
        end

        req = 3'b100;
        step(); chk("t5_en_a", en, 3'b100); chk("t5_owner", owner, 2);
        step(); chk("t5_en_b", en, 3'b100);
        #3 clrn = 1'b0;
        #2;
        chk("t5_async_en", en, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_owner", owner, 0);
        req = 3'b101;
        #1 clrn = 1'b1;
        step(); chk("t5_regrant", en, 3'b001); chk("t5_regrant_owner", owner, 0);
        req = 3'b000;

        req6 = 3'b011;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t6_hold", en6, 3'b001);
            chk("t6_hold_pre", preempt6, 0);
        end
        req6 = 3'b010;
        step(); chk("t6_turn_a", en6, 0); chk("t6_turn_a_pre", preempt6, 0);
        step(); chk("t6_turn_b", en6, 0); chk("t6_turn_b_pre", preempt6, 0);
        step(); chk("t6_grant", en6, 3'b010); chk("t6_owner", owner6, 1);
        chk("t6_busy", busy6, 1);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
